ps2_interface: RTL and testbench



---
 rtl/ps2_interface_if.sv | 19 +
 rtl/ps2_interface.sv | 132 +++++++++++++
 tb/tb_ps2_interface.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_interface_if.sv
// Decoded-key output bundle of the PS/2 receiver.
// The receiver drives the master side; consumers attach to the slave side.
interface ps2_interface_if;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic [7:0] last_data_received;

  modport master (
    output ps2_key_data,
    output ps2_key_pressed,
    output last_data_received
  );

  modport slave (
    input ps2_key_data,
    input ps2_key_pressed,
    input last_data_received
  );
endinterface

// File: rtl/ps2_interface.sv
// PS/2 device-to-host receiver: synchronises and de-glitches the PS/2 lines,
// deframes 11-bit frames, and tracks F0/E0 prefixes to report make codes.
module ps2_interface #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic            clock,
  input  logic            resetn,
  inout  wire             ps2_clock,
  inout  wire             ps2_data,
  ps2_interface_if.master bus
);
  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]     clk_sync_q, data_sync_q;
  logic           filt_q, filt_d, filt_prev_q;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic [1:0]     state_q, state_d;
  logic [3:0]     bitcnt_q, bitcnt_d;
  logic [9:0]     shift_q, shift_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           brk_q, brk_d;
  logic [7:0]     key_q, key_d, last_q, last_d;
  logic           pressed_q, pressed_d;
  logic           fall, sdata, frame_ok;

  assign fall  = filt_prev_q & ~filt_q;
  assign sdata = data_sync_q[1];
  // shift_q holds {stop, parity, data[7:0]}; the start bit is implied by entry to RECV
  assign frame_ok = shift_q[9] & (^shift_q[8:0]);

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
      else                               fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    tcnt_d    = tcnt_q;
    brk_d     = brk_q;
    key_d     = key_q;
    last_d    = last_q;
    pressed_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tcnt_d = '0;
        if (fall && !sdata) begin
          state_d  = ST_RECV;
          bitcnt_d = 4'd1;
          shift_d  = '0;
        end
      end
      ST_RECV: begin
        if (fall) begin
          shift_d = {sdata, shift_q[9:1]};
          tcnt_d  = '0;
          if (bitcnt_q == 4'd10) state_d  = ST_DONE;
          else                   bitcnt_d = bitcnt_q + 4'd1;
        end else if (tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
          state_d  = ST_IDLE;
          bitcnt_d = '0;
          tcnt_d   = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        bitcnt_d = '0;
        if (frame_ok) begin
          key_d     = shift_q[7:0];
          pressed_d = 1'b1;
          if (shift_q[7:0] == 8'hF0)      brk_d = 1'b1;
          else if (shift_q[7:0] == 8'hE0) brk_d = brk_q;
          else if (brk_q)                 brk_d = 1'b0;
          else                            last_d = shift_q[7:0];
        end
      end
      default: begin
        state_d  = ST_IDLE;
        bitcnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      tcnt_q      <= '0;
      brk_q       <= 1'b0;
      key_q       <= '0;
      last_q      <= '0;
      pressed_q   <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clock};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      tcnt_q      <= tcnt_d;
      brk_q       <= brk_d;
      key_q       <= key_d;
      last_q      <= last_d;
      pressed_q   <= pressed_d;
    end
  end

  assign bus.ps2_key_data       = key_q;
  assign bus.ps2_key_pressed    = pressed_q;
  assign bus.last_data_received = last_q;
endmodule

// File: tb/tb_ps2_interface.sv
// Self-checking bench for ps2_interface: table of frames plus timeout,
// glitch and mid-frame reset sequences, with a pulse scoreboard.
module tb_ps2_interface;
  localparam int unsigned TMO = 200;

  logic clock = 1'b0;
  logic resetn;
  logic ps2c_drv, ps2d_drv;
  wire  ps2_clk_w;
  wire  ps2_dat_w;
  assign ps2_clk_w = ps2c_drv;
  assign ps2_dat_w = ps2d_drv;

  ps2_interface_if bus ();

  ps2_interface #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .ps2_clock (ps2_clk_w),
    .ps2_data  (ps2_dat_w),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] key;
    logic [7:0] last;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       bad_par;
    logic       bad_stop;
    logic [7:0] ekey;
    logic [7:0] elast;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  int   exp_pulses = 0;
  logic prev_pressed = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (resetn) begin
      if (bus.ps2_key_pressed) begin
        pulses++;
        checks++;
        if (prev_pressed) begin
          errors++;
          $display("FAIL pulse_width: pressed high 2 cycles, expected 1");
        end
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: key %02h with no frame expected", bus.ps2_key_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_key", bus.ps2_key_data, e.key);
          chk("sb_last", bus.last_data_received, e.last);
        end
      end
      prev_pressed = bus.ps2_key_pressed;
    end else begin
      prev_pressed = 1'b0;
    end
  end

  function automatic logic [10:0] mk(input logic [7:0] d, input logic bp, input logic bs);
    return {~bs, (~^d) ^ bp, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      ps2d_drv = b[i];
      repeat (10) @(posedge clock);
      ps2c_drv = 1'b0;
      repeat (20) @(posedge clock);
      ps2c_drv = 1'b1;
      repeat (10) @(posedge clock);
    end
  endtask

  task automatic expect_frame(input logic [7:0] key, input logic [7:0] last);
    exp_t e;
    e.key  = key;
    e.last = last;
    sb.push_back(e);
    exp_pulses++;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected pulse(s) missing, expected 0", name, sb.size());
      sb.delete();
    end
    ps2d_drv = 1'b1;
    repeat (20) @(posedge clock);
  endtask

  vec_t vt[12];

  initial begin
    vt[0]  = '{8'h1C, 1'b0, 1'b0, 8'h1C, 8'h1C};
    vt[1]  = '{8'hF0, 1'b0, 1'b0, 8'hF0, 8'h1C};
    vt[2]  = '{8'h32, 1'b0, 1'b0, 8'h32, 8'h1C};
    vt[3]  = '{8'h1C, 1'b1, 1'b0, 8'h32, 8'h1C};
    vt[4]  = '{8'h24, 1'b0, 1'b0, 8'h24, 8'h24};
    vt[5]  = '{8'hE0, 1'b0, 1'b0, 8'hE0, 8'h24};
    vt[6]  = '{8'h75, 1'b0, 1'b0, 8'h75, 8'h75};
    vt[7]  = '{8'h5A, 1'b0, 1'b1, 8'h75, 8'h75};
    vt[8]  = '{8'hF0, 1'b0, 1'b0, 8'hF0, 8'h75};
    vt[9]  = '{8'hE0, 1'b0, 1'b0, 8'hE0, 8'h75};
    vt[10] = '{8'h12, 1'b0, 1'b0, 8'h12, 8'h75};
    vt[11] = '{8'h29, 1'b0, 1'b0, 8'h29, 8'h29};

    resetn   = 1'b0;
    ps2c_drv = 1'b1;
    ps2d_drv = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("rst_key", bus.ps2_key_data, 8'h00);
    chk("rst_pressed", {7'd0, bus.ps2_key_pressed}, 8'h00);
    chk("rst_last", bus.last_data_received, 8'h00);
    @(negedge clock);
    resetn = 1'b1;
    repeat (20) @(posedge clock);

    for (int v = 0; v < 12; v++) begin
      if (!vt[v].bad_par && !vt[v].bad_stop) expect_frame(vt[v].ekey, vt[v].elast);
      send_bits(mk(vt[v].d, vt[v].bad_par, vt[v].bad_stop), 11);
      wait_drain("vec_drain");
      @(negedge clock);
      chk("vec_key", bus.ps2_key_data, vt[v].ekey);
      chk("vec_last", bus.last_data_received, vt[v].elast);
    end

    // partial frame abandoned by timeout, then a clean frame
    send_bits(mk(8'h45, 1'b0, 1'b0), 5);
    ps2d_drv = 1'b1;
    repeat (TMO + 50) @(posedge clock);
    expect_frame(8'h45, 8'h45);
    send_bits(mk(8'h45, 1'b0, 1'b0), 11);
    wait_drain("timeout_drain");
    @(negedge clock);
    chk("timeout_key", bus.ps2_key_data, 8'h45);

    // 2-cycle low glitch on ps2_clock mid-frame must not shift a bit
    expect_frame(8'h33, 8'h33);
    send_bits(mk(8'h33, 1'b0, 1'b0), 4);
    ps2c_drv = 1'b0;
    repeat (2) @(posedge clock);
    ps2c_drv = 1'b1;
    send_bits(mk(8'h33, 1'b0, 1'b0) >> 4, 7);
    wait_drain("glitch_drain");
    @(negedge clock);
    chk("glitch_key", bus.ps2_key_data, 8'h33);
    chk("glitch_last", bus.last_data_received, 8'h33);

    // reset mid-frame
    send_bits(mk(8'h6B, 1'b0, 1'b0), 5);
    resetn = 1'b0;
    #1;
    chk("midrst_key", bus.ps2_key_data, 8'h00);
    chk("midrst_pressed", {7'd0, bus.ps2_key_pressed}, 8'h00);
    chk("midrst_last", bus.last_data_received, 8'h00);
    ps2d_drv = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    repeat (20) @(posedge clock);
    expect_frame(8'h16, 8'h16);
    send_bits(mk(8'h16, 1'b0, 1'b0), 11);
    wait_drain("postrst_drain");
    @(negedge clock);
    chk("postrst_key", bus.ps2_key_data, 8'h16);
    chk("postrst_last", bus.last_data_received, 8'h16);

    checks++;
    if (pulses != exp_pulses) begin
      errors++;
      $display("FAIL pulse_count: got %0d expected %0d", pulses, exp_pulses);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
